// File: rtl/ps2_pkg.sv
// Shared PS/2 Set 2 definitions: prefix bytes, keyboard status codes and the
// decoder FSM state type.
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  // Keyboard status/response bytes that never carry a key event.
  localparam logic [7:0] PS2_ERR_LO   = 8'h00;
  localparam logic [7:0] PS2_BAT_OK   = 8'hAA;
  localparam logic [7:0] PS2_ECHO     = 8'hEE;
  localparam logic [7:0] PS2_ACK      = 8'hFA;
  localparam logic [7:0] PS2_BAT_FAIL = 8'hFC;
  localparam logic [7:0] PS2_RESEND   = 8'hFE;
  localparam logic [7:0] PS2_ERR_HI   = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    BREAK,
    EXT,
    EXT_BREAK
  } ps2_state_e;

  function automatic logic is_status_code(input logic [7:0] code);
    return (code == PS2_ERR_LO)   || (code == PS2_BAT_OK) ||
           (code == PS2_ECHO)     || (code == PS2_ACK)    ||
           (code == PS2_BAT_FAIL) || (code == PS2_RESEND) ||
           (code == PS2_ERR_HI);
  endfunction

endpackage

// File: rtl/ps2_set2_to_ascii.sv
// Combinational Set 2 make-code to uppercase ASCII lookup; valid flags codes
// that have a character.
module ps2_set2_to_ascii (
  input  logic [7:0] code,
  output logic [7:0] ascii,
  output logic       valid
);

  // NOTE: every output gets a default before the case so no path through the
  // block leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    ascii = 8'h00;
    valid = 1'b1;
    case (code)
      8'h1C: ascii = "A";
      8'h32: ascii = "B";
      8'h21: ascii = "C";
      8'h23: ascii = "D";
      8'h24: ascii = "E";
      8'h2B: ascii = "F";
      8'h34: ascii = "G";
      8'h33: ascii = "H";
      8'h43: ascii = "I";
      8'h3B: ascii = "J";
      8'h42: ascii = "K";
      8'h4B: ascii = "L";
      8'h3A: ascii = "M";
      8'h31: ascii = "N";
      8'h44: ascii = "O";
      8'h4D: ascii = "P";
      8'h15: ascii = "Q";
      8'h2D: ascii = "R";
      8'h1B: ascii = "S";
      8'h2C: ascii = "T";
      8'h3C: ascii = "U";
      8'h2A: ascii = "V";
      8'h1D: ascii = "W";
      8'h22: ascii = "X";
      8'h35: ascii = "Y";
      8'h1A: ascii = "Z";
      8'h45: ascii = "0";
      8'h16: ascii = "1";
      8'h1E: ascii = "2";
      8'h26: ascii = "3";
      8'h25: ascii = "4";
      8'h2E: ascii = "5";
      8'h36: ascii = "6";
      8'h3D: ascii = "7";
      8'h3E: ascii = "8";
      8'h46: ascii = "9";
      8'h29: ascii = " ";
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Turns the raw PS/2 byte stream into one ASCII strobe per key press,
// discarding breaks, extended keys, auto-repeat and status bytes.
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ps2_received_data,
  input  logic       ps2_received_data_strb,
  output logic [7:0] ascii_data,
  output logic       ascii_strb
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  ps2_state_e       state;
  ps2_state_e       next_state;
  logic [CNT_W-1:0] timeout_cnt;
  logic [7:0]       last_make;
  logic [7:0]       map_ascii;
  logic             map_valid;
  logic             timed_out;
  logic             emit;
  logic             clear_last;

  ps2_set2_to_ascii u_map (
    .code  (ps2_received_data),
    .ascii (map_ascii),
    .valid (map_valid)
  );

  // A strobe on the expiry cycle takes priority, so expiry needs no strobe.
  assign timed_out = (state != IDLE) && !ps2_received_data_strb &&
                     (timeout_cnt == CNT_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (ps2_received_data_strb) begin
      unique case (state)
        IDLE: begin
          if (ps2_received_data == PS2_BREAK)    next_state = BREAK;
          else if (ps2_received_data == PS2_EXT) next_state = EXT;
        end
        EXT: begin
          if (ps2_received_data == PS2_BREAK) next_state = EXT_BREAK;
          else                                next_state = IDLE;
        end
        BREAK, EXT_BREAK: next_state = IDLE;
        default:          next_state = IDLE;
      endcase
    end else if (timed_out) begin
      next_state = IDLE;
    end
  end

  // Status bytes are never mapped, so a mapped IDLE byte is a genuine make.
  always_comb begin
    emit       = 1'b0;
    clear_last = 1'b0;
    if (ps2_received_data_strb) begin
      if (state == IDLE) begin
        emit = map_valid && !is_status_code(ps2_received_data) &&
               (ps2_received_data != last_make);
      end else if (state == BREAK) begin
        clear_last = (ps2_received_data == last_make);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_cnt <= '0;
    end else if (ps2_received_data_strb || next_state == IDLE) begin
      timeout_cnt <= '0;
    end else begin
      timeout_cnt <= timeout_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ascii_data <= 8'h00;
      ascii_strb <= 1'b0;
      last_make  <= 8'h00;
    end else begin
      ascii_strb <= emit;
      if (emit) begin
        ascii_data <= map_ascii;
        last_make  <= ps2_received_data;
      end else if (clear_last) begin
        last_make <= 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed scoreboard bench: stimulus queues expected ASCII bytes and the
// cycle they must appear in; a monitor pops and compares each output pulse.
module tb_ps2_scancode_decoder;

  localparam int TIMEOUT = 16;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ps2_received_data;
  logic       ps2_received_data_strb;
  logic [7:0] ascii_data;
  logic       ascii_strb;

  exp_t exp_q[$];
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;

  ps2_scancode_decoder #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .ps2_received_data      (ps2_received_data),
    .ps2_received_data_strb (ps2_received_data_strb),
    .ascii_data             (ascii_data),
    .ascii_strb             (ascii_strb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Drives one byte for the next edge; strobe stays high so calls chain
  // back to back. With exp set, a pulse is expected right after that edge.
  task automatic send(input logic [7:0] b, input logic exp, input logic [7:0] a);
    exp_t e;
    @(negedge clk);
    ps2_received_data      = b;
    ps2_received_data_strb = 1'b1;
    if (exp) begin
      e.data = a;
      e.cyc  = cyc + 1;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    ps2_received_data_strb = 1'b0;
    ps2_received_data      = 8'h00;
    repeat (n - 1) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && ascii_strb === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse: got ascii 0x%0h at cycle %0d, expected no pulse",
                 ascii_data, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("ascii_data", int'(ascii_data), int'(e.data));
        check("pulse_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    rst_n                  = 1'b0;
    ps2_received_data      = 8'h00;
    ps2_received_data_strb = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_ascii_data", int'(ascii_data), 0);
    check("reset_ascii_strb", int'(ascii_strb), 0);
    rst_n = 1'b1;
    idle(2);

    // Press and release A.
    send(8'h1C, 1'b1, 8'h41);
    idle(2);
    send(8'hF0, 1'b0, 8'h00);
    send(8'h1C, 1'b0, 8'h00);
    idle(3);

    // Auto-repeat, back to back.
    send(8'h1C, 1'b1, 8'h41);
    send(8'h1C, 1'b0, 8'h00);
    send(8'h1C, 1'b0, 8'h00);
    send(8'hF0, 1'b0, 8'h00);
    send(8'h1C, 1'b0, 8'h00);
    send(8'h1C, 1'b1, 8'h41);
    idle(3);

    // Extended make/break and status bytes, then digit 0.
    send(8'hE0, 1'b0, 8'h00);
    send(8'h75, 1'b0, 8'h00);
    send(8'hE0, 1'b0, 8'h00);
    send(8'hF0, 1'b0, 8'h00);
    send(8'h75, 1'b0, 8'h00);
    send(8'hAA, 1'b0, 8'h00);
    send(8'hFA, 1'b0, 8'h00);
    send(8'hFF, 1'b0, 8'h00);
    send(8'h45, 1'b1, 8'h30);
    idle(3);

    // Unmapped code, then space.
    send(8'h05, 1'b0, 8'h00);
    send(8'h29, 1'b1, 8'h20);
    idle(3);

    // Break prefix abandoned after the timeout: 32 is a fresh make.
    send(8'hF0, 1'b0, 8'h00);
    idle(TIMEOUT);
    send(8'h32, 1'b1, 8'h42);
    idle(3);

    // Strobe lands on the expiry cycle: treated as the release of B,
    // which clears last_make so the next B press is emitted.
    send(8'hF0, 1'b0, 8'h00);
    idle(TIMEOUT - 1);
    send(8'h32, 1'b0, 8'h00);
    idle(3);
    send(8'h32, 1'b1, 8'h42);
    idle(3);

    // Reset in the middle of a break sequence.
    send(8'hF0, 1'b0, 8'h00);
    @(negedge clk);
    ps2_received_data_strb = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midreset_ascii_data", int'(ascii_data), 0);
    check("midreset_ascii_strb", int'(ascii_strb), 0);
    repeat (3) begin
      @(negedge clk);
      check("midreset_hold_data", int'(ascii_data), 0);
    end
    rst_n = 1'b1;
    idle(2);
    send(8'h2D, 1'b1, 8'h52);
    idle(3);

    // Assorted map entries, back to back.
    send(8'h15, 1'b1, 8'h51);
    send(8'h1A, 1'b1, 8'h5A);
    send(8'h16, 1'b1, 8'h31);
    send(8'h46, 1'b1, 8'h39);
    send(8'h4D, 1'b1, 8'h50);
    idle(5);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
